alu_addsub_iter: RTL and testbench
==================================

Name: alu_addsub_iter

Overview:
- Parametrised multi-cycle integer ALU for the RISC32i datapath.
- Performs add, subtract, set-less-than and bitwise logic on WIDTH-bit operands.
- Arithmetic ripples through a CHUNK-bit adder slice, one slice per cycle, trading latency for area and timing.
- Sits between the decode/operand registers and writeback. Uses a start/ready input handshake and a valid/ready result handshake.

Parameters:
- WIDTH, 32, operand/result width. Must be a multiple of CHUNK; otherwise elaboration fails.
- CHUNK, 8, adder slice width per cycle. N = WIDTH/CHUNK arithmetic cycles; CHUNK = WIDTH gives single-cycle arithmetic.

Ports:
- clk_in  input  1  clock, all state on rising edge
- rst_n_in  input  1  asynchronous active-low reset
- start_in  input  1  request; accepted when start_in && ready_out at a rising edge
- op_in  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT, 110 SLTU, 111 reserved
- A_in  input  WIDTH  operand A, sampled at acceptance
- B_in  input  WIDTH  operand B, sampled at acceptance
- ready_out  output  1  high only in IDLE
- res_valid_out  output  1  result valid
- res_ready_in  input  1  consumer accepts result when res_valid_out && res_ready_in
- S_out  output  WIDTH  result
- C_out  output  1  final carry-out of the adder (SUB: 1 = no borrow)
- err_out  output  1  unsigned overflow: ADD carry-out, SUB borrow (~carry)
- ovf_out  output  1  signed overflow for ADD/SUB
- zero_out  output  1  S_out == 0

Behaviour:
- FSM states: IDLE, BUSY, DONE. Reset places the FSM in IDLE.
- ready_out = (state == IDLE), so it is 1 out of reset. No new request is accepted until the current result is consumed.
- Reset values: S_out = 0, C_out = 0, err_out = 0, ovf_out = 0, res_valid_out = 0. zero_out follows S_out (1 after reset). Internal chunk counter, carry and partial sum are cleared.
- Acceptance edge:
  - latch A, Bx = B_in ^ {WIDTH{sub}}, carry = sub, where sub = 1 for SUB/SLT/SLTU;
  - latch op; clear the chunk counter k; go to BUSY.
- BUSY, arithmetic ops (ADD/SUB/SLT/SLTU): each cycle computes {c, P[k*CHUNK +: CHUNK]} = A chunk + Bx chunk + carry, then carry <= c and k <= k+1.
  - On chunk N-1, also form: signed ovf = (A[msb] == Bx[msb]) && (P[msb] != A[msb]); final carry = c.
  - Then load outputs and go to DONE.
- BUSY, logic ops (AND/OR/XOR/111): compute in the first BUSY cycle, load outputs and go to DONE.
- Latency from acceptance edge to res_valid_out rising: N cycles for arithmetic, 1 cycle for logic.
- Output loading on completion:
  - ADD/SUB: S = P, C_out = final carry, err_out = ADD ? carry : ~carry, ovf_out = ovf.
  - SLT: S = {0…, P[msb] ^ ovf}. SLTU: S = {0…, ~carry}. C_out = carry; err_out = 0; ovf_out = 0.
  - AND/OR/XOR: bitwise result; C_out = 0, err_out = 0, ovf_out = 0.
  - 111: S = 0, all flags 0.
- DONE: res_valid_out = 1. S_out and all flags are registered and held stable while res_ready_in = 0.
  - On res_valid_out && res_ready_in, go to IDLE and drop res_valid_out.
  - S_out and flags keep their last value until the next completion.
- start_in outside IDLE is ignored. Operand or op changes after acceptance have no effect.
- Partial sums never appear on S_out.
- Reset mid-operation (BUSY or DONE) aborts immediately and asynchronously: outputs take their reset values and ready_out = 1. The first operation after reset deassertion is computed correctly.
- Carry between slices propagates strictly in order k = 0..N-1. Wrap-around is modulo 2^WIDTH.

Test Plan (WIDTH=32, CHUNK=8, N=4):
- ADD 0x7FFFFFFF + 0x00000001 -> after 4 cycles: S=0x80000000, ovf=1, err=0, C=0, zero=0. ADD 0xFFFFFFFF + 1 -> S=0, zero=1, C=1, err=1, ovf=0.
- SUB 0x00000000 - 0x00000001 -> S=0xFFFFFFFF, C=0, err=1, ovf=0. SUB 0x80000000 - 1 -> S=0x7FFFFFFF, ovf=1, err=0.
- SLT A=0x80000000, B=0x00000001 -> S=1. SLTU with the same operands -> S=0. SLT 5, 5 -> S=0, zero=1.
- XOR 0xF0F0F0F0 ^ 0xFFFF0000 -> S=0x0F0FF0F0, res_valid_out 1 cycle after acceptance. OR and AND with the same operands -> 0xFFFFF0F0 and 0xF0F00000. op 111 -> S=0, flags 0.
- Backpressure: hold res_ready_in=0 for 5 cycles after valid while pulsing start_in with new operands -> S_out and flags stable, ready_out=0, no new op accepted. Raising res_ready_in -> IDLE next cycle and ready_out=1.
- Pull rst_n_in low during chunk 2 of an ADD -> immediate reset values and ready_out=1. A following ADD 0x12345678 + 0x11111111 -> S=0x23456789.
- Rebuild with CHUNK=32 -> 1-cycle latency for ADD.

Source files
------------

// File: rtl/alu_addsub_iter.sv
// ---------------------------------------------------------------------------
// alu_addsub_iter
//   Multi-cycle integer ALU for the RISC32i datapath. Add, subtract and the
//   set-less-than compares ripple through one CHUNK-bit adder slice per cycle
//   (N = WIDTH/CHUNK cycles). Bitwise ops finish in a single cycle.
//
// Ports
//   clk_in         clock, all state on the rising edge
//   rst_n_in       asynchronous active-low reset
//   start_in       request, taken when start_in && ready_out
//   op_in[2:0]     000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR,
//                  101 SLT, 110 SLTU, 111 reserved (result 0)
//   A_in, B_in     operands, sampled on acceptance
//   ready_out      high only while idle
//   res_valid_out  result valid, held until res_ready_in
//   res_ready_in   consumer takes the result when valid && ready
//   S_out          result
//   C_out          adder carry-out (SUB: 1 = no borrow)
//   err_out        unsigned overflow (ADD carry, SUB borrow)
//   ovf_out        signed overflow for ADD/SUB
//   zero_out       S_out == 0
// ---------------------------------------------------------------------------
module alu_addsub_iter #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             start_in,
    input  logic [2:0]       op_in,
    input  logic [WIDTH-1:0] A_in,
    input  logic [WIDTH-1:0] B_in,
    output logic             ready_out,
    output logic             res_valid_out,
    input  logic             res_ready_in,
    output logic [WIDTH-1:0] S_out,
    output logic             C_out,
    output logic             err_out,
    output logic             ovf_out,
    output logic             zero_out
);

    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    generate
        if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
            $error("alu_addsub_iter: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_SLT  = 3'b101;
    localparam logic [2:0] OP_SLTU = 3'b110;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    // One adder slice: {carry_out, sum} of two chunks plus carry-in.
    function automatic logic [CHUNK:0] slice_add(input logic [CHUNK-1:0] a,
                                                 input logic [CHUNK-1:0] b,
                                                 input logic             cin);
        return {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    endfunction

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] bx_q;       // B, inverted for subtract-type ops
    logic [WIDTH-1:0] p_q;        // partial sum, never exposed on S_out
    logic             carry_q;
    logic [KW-1:0]    k_q;
    logic [2:0]       op_q;

    logic [WIDTH-1:0] s_q;
    logic             c_q;
    logic             err_q;
    logic             ovf_q;
    logic             valid_q;

    logic [CHUNK-1:0] a_ch;
    logic [CHUNK-1:0] b_ch;
    logic [CHUNK:0]   sum;
    logic [WIDTH-1:0] p_next;
    logic             c_fin;
    logic             ovf_fin;
    logic             last_chunk;
    logic             sub_in;
    logic             arith_q;

    assign sub_in  = (op_in == OP_SUB) || (op_in == OP_SLT) || (op_in == OP_SLTU);
    assign arith_q = (op_q == OP_ADD) || (op_q == OP_SUB) ||
                     (op_q == OP_SLT) || (op_q == OP_SLTU);
    assign last_chunk = (k_q == KW'(N - 1));

    // Select the active chunk with constant indices so the mux stays a
    // plain N-way select rather than a variable shifter.
    always_comb begin
        a_ch   = '0;
        b_ch   = '0;
        for (int i = 0; i < N; i++) begin
            if (k_q == KW'(i)) begin
                a_ch = a_q[i*CHUNK +: CHUNK];
                b_ch = bx_q[i*CHUNK +: CHUNK];
            end
        end
        sum    = slice_add(a_ch, b_ch, carry_q);
        p_next = p_q;
        for (int i = 0; i < N; i++) begin
            if (k_q == KW'(i)) begin
                p_next[i*CHUNK +: CHUNK] = sum[CHUNK-1:0];
            end
        end
        c_fin   = sum[CHUNK];
        // Signed overflow: both addends share a sign the result does not.
        ovf_fin = (a_q[WIDTH-1] == bx_q[WIDTH-1]) && (p_next[WIDTH-1] != a_q[WIDTH-1]);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state   <= IDLE;
            a_q     <= '0;
            bx_q    <= '0;
            p_q     <= '0;
            carry_q <= 1'b0;
            k_q     <= '0;
            op_q    <= '0;
            s_q     <= '0;
            c_q     <= 1'b0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_in) begin
                        a_q     <= A_in;
                        bx_q    <= B_in ^ {WIDTH{sub_in}};
                        carry_q <= sub_in;
                        op_q    <= op_in;
                        k_q     <= '0;
                        state   <= BUSY;
                    end
                end

                BUSY: begin
                    if (arith_q) begin
                        p_q     <= p_next;
                        carry_q <= c_fin;
                        k_q     <= k_q + KW'(1);
                        if (last_chunk) begin
                            valid_q <= 1'b1;
                            state   <= DONE;
                            c_q     <= c_fin;
                            case (op_q)
                                OP_ADD: begin
                                    s_q   <= p_next;
                                    err_q <= c_fin;
                                    ovf_q <= ovf_fin;
                                end
                                OP_SUB: begin
                                    s_q   <= p_next;
                                    err_q <= ~c_fin;
                                    ovf_q <= ovf_fin;
                                end
                                OP_SLT: begin
                                    s_q   <= {{(WIDTH-1){1'b0}}, p_next[WIDTH-1] ^ ovf_fin};
                                    err_q <= 1'b0;
                                    ovf_q <= 1'b0;
                                end
                                default: begin  // SLTU
                                    s_q   <= {{(WIDTH-1){1'b0}}, ~c_fin};
                                    err_q <= 1'b0;
                                    ovf_q <= 1'b0;
                                end
                            endcase
                        end
                    end else begin
                        case (op_q)
                            OP_AND:  s_q <= a_q & bx_q;
                            OP_OR:   s_q <= a_q | bx_q;
                            OP_XOR:  s_q <= a_q ^ bx_q;
                            default: s_q <= '0;
                        endcase
                        c_q     <= 1'b0;
                        err_q   <= 1'b0;
                        ovf_q   <= 1'b0;
                        valid_q <= 1'b1;
                        state   <= DONE;
                    end
                end

                DONE: begin
                    if (res_ready_in) begin
                        valid_q <= 1'b0;
                        state   <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign ready_out     = (state == IDLE);
    assign res_valid_out = valid_q;
    assign S_out         = s_q;
    assign C_out         = c_q;
    assign err_out       = err_q;
    assign ovf_out       = ovf_q;
    assign zero_out      = (s_q == '0);

endmodule

// File: tb/tb_alu_addsub_iter.sv
module tb_alu_addsub_iter;

    localparam int WIDTH = 32;
    localparam int CHUNK = 8;
    localparam int LAT_ARITH = WIDTH / CHUNK;

    localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011,
                           XOR_ = 3'b100, SLT = 3'b101, SLTU = 3'b110, RSV = 3'b111;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [2:0]       op = '0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             ready;
    logic             res_valid;
    logic             res_ready = 1'b1;
    logic [WIDTH-1:0] s;
    logic             c, err, ovf, zero;

    alu_addsub_iter #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start), .op_in(op),
        .A_in(a), .B_in(b), .ready_out(ready), .res_valid_out(res_valid),
        .res_ready_in(res_ready), .S_out(s), .C_out(c), .err_out(err),
        .ovf_out(ovf), .zero_out(zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [WIDTH-1:0] s;
        logic             c, err, ovf, zero;
        int               lat;
        int               acc;
        string            name;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic prev_valid = 1'b0;

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: compares every cycle the result is presented (which also
    // checks stability under backpressure), pops on the handshake.
    always @(negedge clk) begin
        if (rst_n && res_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_result: got S=0x%08h with nothing outstanding", s);
            end else begin
                exp_t e;
                e = exp_q[0];
                if (!prev_valid)
                    chk({e.name, "_latency"}, WIDTH'(cyc - e.acc), WIDTH'(e.lat));
                chk({e.name, "_S"}, s, e.s);
                chk({e.name, "_flags(c,err,ovf,zero)"}, WIDTH'({c, err, ovf, zero}),
                    WIDTH'({e.c, e.err, e.ovf, e.zero}));
                if (res_ready) void'(exp_q.pop_front());
            end
        end
        prev_valid = rst_n && res_valid;
    end

    task automatic issue(input string name, input logic [2:0] o, input logic [WIDTH-1:0] ia,
                         input logic [WIDTH-1:0] ib, input logic [WIDTH-1:0] es,
                         input logic ec, input logic eerr, input logic eovf,
                         input int lat, input bit push);
        int g;
        exp_t e;
        g = 0;
        while (!ready && g < 200) begin
            @(posedge clk); #1;
            g++;
        end
        if (!ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_ready_timeout: ready_out=%0b, expected 1", name, ready);
        end else begin
            start = 1'b1; op = o; a = ia; b = ib;
            @(posedge clk); #1;
            start = 1'b0;
            if (push) begin
                e.s = es; e.c = ec; e.err = eerr; e.ovf = eovf; e.zero = (es == '0);
                e.lat = lat; e.acc = cyc; e.name = name;
                exp_q.push_back(e);
            end
            // Scramble inputs: changes after acceptance must not matter.
            a = 32'hDEADBEEF; b = 32'h0BADF00D; op = RSV;
        end
    endtask

    task automatic drain;
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 200) begin
            @(posedge clk); #1;
            g++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        // Reset state
        #12;
        chk("reset_S", s, '0);
        chk("reset_flags", WIDTH'({c, err, ovf, zero, res_valid}), WIDTH'(5'b00010));
        chk("reset_ready", WIDTH'(ready), 1);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Arithmetic
        issue("add_sovf",  ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 0, 1, LAT_ARITH, 1);
        issue("add_wrap",  ADD, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1, 1, 0, LAT_ARITH, 1);
        issue("sub_borrow",SUB, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 0, 1, 0, LAT_ARITH, 1);
        issue("sub_sovf",  SUB, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1, 0, 1, LAT_ARITH, 1);
        issue("sub_plain", SUB, 32'h00000105, 32'h00000003, 32'h00000102, 1, 0, 0, LAT_ARITH, 1);
        issue("slt_neg",   SLT, 32'h80000000, 32'h00000001, 32'h00000001, 1, 0, 0, LAT_ARITH, 1);
        issue("sltu",      SLTU,32'h80000000, 32'h00000001, 32'h00000000, 1, 0, 0, LAT_ARITH, 1);
        issue("slt_eq",    SLT, 32'h00000005, 32'h00000005, 32'h00000000, 1, 0, 0, LAT_ARITH, 1);
        issue("sltu_lt",   SLTU,32'h00000003, 32'hFFFFFFF0, 32'h00000001, 0, 0, 0, LAT_ARITH, 1);

        // Logic ops, then reserved after a nonzero result
        issue("xor", XOR_, 32'hF0F0F0F0, 32'hFFFF0000, 32'h0F0FF0F0, 0, 0, 0, 1, 1);
        issue("or",  OR_,  32'hF0F0F0F0, 32'hFFFF0000, 32'hFFFFF0F0, 0, 0, 0, 1, 1);
        issue("and", AND_, 32'hF0F0F0F0, 32'hFFFF0000, 32'hF0F00000, 0, 0, 0, 1, 1);
        issue("rsv", RSV,  32'hF0F0F0F0, 32'hFFFF0000, 32'h00000000, 0, 0, 0, 1, 1);
        drain();

        // Backpressure: result held, start ignored
        res_ready = 1'b0;
        issue("bp_add", ADD, 32'h00000001, 32'h00000002, 32'h00000003, 0, 0, 0, LAT_ARITH, 1);
        begin
            int g;
            g = 0;
            while (!res_valid && g < 50) begin
                @(posedge clk); #1;
                g++;
            end
        end
        chk("bp_valid_seen", WIDTH'(res_valid), 1);
        for (int i = 0; i < 5; i++) begin
            start = 1'b1; op = SUB; a = 32'h11111111 * (i + 1); b = 32'h1;
            @(posedge clk); #1;
            chk("bp_ready_low", WIDTH'(ready), 0);
        end
        start = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_ready", WIDTH'(ready), 1);
        chk("bp_release_valid", WIDTH'(res_valid), 0);
        chk("bp_S_held", s, 32'h00000003);
        repeat (LAT_ARITH + 2) @(posedge clk);
        #1;
        chk("bp_no_extra_op", WIDTH'(res_valid), 0);

        // Reset during chunk 2 of an ADD
        issue("rst_abort", ADD, 32'hAAAAAAAA, 32'h55555555, 32'h0, 0, 0, 0, LAT_ARITH, 0);
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_S", s, '0);
        chk("midrst_flags", WIDTH'({c, err, ovf, zero, res_valid}), WIDTH'(5'b00010));
        chk("midrst_ready", WIDTH'(ready), 1);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        issue("post_rst_add", ADD, 32'h12345678, 32'h11111111, 32'h23456789, 0, 0, 0, LAT_ARITH, 1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
